apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB master command port among REQ_NUM local requesters.
- Sits between requesters (DMA, CPU bridge, config engines) and the APB master.
- Latches the winning requester's command and holds m_transfer until the master reports completion.
- Returns read data and error status to the owner, with a watchdog that aborts stalled transfers.

Parameters:
ADDR_WIDTH, 8, address width per requester and on m_addr
DATA_WIDTH, 8, data width of write/read data
REQ_NUM, 4, number of requesters (>=2)
SEL_WIDTH, 1, width of slave-select index
TIMEOUT, 16, max cycles in BUSY before abort; 0 disables watchdog
CNT_WIDTH, 8, watchdog counter width (must hold TIMEOUT)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  synchronous active-low reset
req  in  REQ_NUM  request per requester, level
req_wr  in  REQ_NUM  1=write, 0=read, per requester
req_addr  in  REQ_NUM*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  REQ_NUM*DATA_WIDTH  packed write data
req_sel  in  REQ_NUM*SEL_WIDTH  packed slave index
gnt  out  REQ_NUM  one-hot current owner (BUSY, DONE)
ack  out  REQ_NUM  one-cycle completion pulse to owner
rsp_rdata  out  DATA_WIDTH  read data, valid with ack
rsp_err  out  1  error flag, valid with ack
m_transfer  out  1  command valid to APB master
m_rw  out  1  latched req_wr of owner
m_addr  out  ADDR_WIDTH  latched address
m_wdata  out  DATA_WIDTH  latched write data
m_sel  out  SEL_WIDTH  latched slave index
m_done  in  1  transfer complete (PENABLE & PREADY from bus)
m_rdata  in  DATA_WIDTH  read data from master
m_err  in  1  PSLVERR from master

Behaviour:
- Reset (PRESETn=0 at edge): state=IDLE; all outputs 0; watchdog=0; priority pointer last=REQ_NUM-1 (req[0] highest after reset).
- All outputs registered.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If |req, pick winner w = first set bit scanning last+1, last+2, ... modulo REQ_NUM (wrap-around).
  - Latch req_wr/addr/wdata/sel of w into m_*.
  - Set gnt=onehot(w), m_transfer=1, last=w, watchdog=0, go BUSY.
  - Otherwise stay in IDLE; m_* hold their last values.
- BUSY:
  - m_transfer=1 and m_* stable.
  - m_done=1: capture rsp_rdata = m_rw ? 0 : m_rdata, rsp_err = m_err; set ack=onehot(w), m_transfer=0; go DONE.
  - Else, if TIMEOUT!=0 and watchdog==TIMEOUT-1: abort with rsp_rdata=0, rsp_err=1, ack=onehot(w), m_transfer=0; go DONE.
  - Else watchdog+1.
  - m_done has priority over timeout on the same cycle.
- DONE:
  - ack cleared next edge; gnt cleared; go IDLE.
  - rsp_rdata/rsp_err hold until the next completion.
- Latency:
  - Request sampled at edge k → m_transfer high after edge k.
  - m_done sampled at edge n → ack high for cycle n..n+1.
  - Minimum 3 cycles per transaction (IDLE, BUSY, DONE).
  - Continuous requesters are served strictly alternating, with no starvation.
- Requester rules:
  - Requester keeps req and fields stable until its ack.
  - Fields are sampled only at grant; later changes are ignored.
  - Dropping req during BUSY does not cancel the transfer; ack is still pulsed.
- m_done in IDLE or DONE is ignored; no state change.
- Single requester with req held high: re-granted every 3+ cycles.
- Reset mid-BUSY: immediate return to IDLE; m_transfer=0; no ack issued; pointer reset.

Test Plan:
- Reset, then req=4'b0001, wr=1, addr=0x10, wdata=0xA5; m_done 2 cycles after m_transfer → m_addr=0x10, m_wdata=0xA5, m_rw=1; ack=4'b0001 for exactly 1 cycle; rsp_err=0.
- req=4'b1111 held, m_done=1 one cycle after each m_transfer → grant order 0,1,2,3,0.
- Read by req2 addr=0x3C, m_rdata=0x5A with m_err=1 → ack=4'b0100, rsp_rdata=0x5A, rsp_err=1.
- TIMEOUT=16, m_done never asserted → m_transfer high exactly 16 cycles; ack pulse with rsp_err=1, rsp_rdata=0; then IDLE.
- last=3 after a grant to req3, req=4'b1001 → next grant req0 (wrap); next grant req3.
- PRESETn=0 during BUSY → next cycle m_transfer=0, gnt=0, ack=0; after release, req=4'b1000 → granted req3 only after req0..2 found idle.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Round-robin arbiter/sequencer sharing one APB master command port among
//   REQ_NUM requesters. The winning requester's command is latched onto m_*,
//   m_transfer is held until the master reports completion (m_done) or the
//   watchdog expires, then a one-cycle ack returns read data and error status.
//
// Ports
//   PCLK, PRESETn  : clock, synchronous active-low reset
//   req/req_wr     : per-requester request level and direction (1=write)
//   req_addr/wdata/sel : packed per-requester command fields
//   gnt            : one-hot owner while BUSY/DONE
//   ack            : one-hot completion pulse to owner
//   rsp_rdata/err  : response, valid with ack, held until next completion
//   m_transfer/m_rw/m_addr/m_wdata/m_sel : command to APB master
//   m_done/m_rdata/m_err : completion from APB master
module apb_req_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned SEL_WIDTH  = 1,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic [REQ_NUM-1:0]              req,
   input  logic [REQ_NUM-1:0]              req_wr,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_addr,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_wdata,
   input  logic [REQ_NUM*SEL_WIDTH-1:0]    req_sel,
   output logic [REQ_NUM-1:0]              gnt,
   output logic [REQ_NUM-1:0]              ack,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic                            rsp_err,
   output logic                            m_transfer,
   output logic                            m_rw,
   output logic [ADDR_WIDTH-1:0]           m_addr,
   output logic [DATA_WIDTH-1:0]           m_wdata,
   output logic [SEL_WIDTH-1:0]            m_sel,
   input  logic                            m_done,
   input  logic [DATA_WIDTH-1:0]           m_rdata,
   input  logic                            m_err
);

   localparam int unsigned IdxW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                  state_q;
   logic [IdxW-1:0]         last_q;
   logic [CNT_WIDTH-1:0]    wd_q;
   logic [REQ_NUM-1:0]      gnt_q;
   logic [REQ_NUM-1:0]      ack_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;
   logic                    transfer_q;
   logic                    rw_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [SEL_WIDTH-1:0]    sel_q;

   // Winner selection
   int unsigned             scan_pos;
   int unsigned             win_pos;
   logic                    win_found;
   logic [REQ_NUM-1:0]      win_oh;
   logic                    win_wr;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;
   logic [SEL_WIDTH-1:0]    win_sel;
   logic                    wd_expired;

   // Scan last+1, last+2, ... modulo REQ_NUM; the first set bit wins. Inner loops compare
   // against constant indices so every select stays a static slice.
   always_comb begin
      scan_pos  = 0;
      win_pos   = 0;
      win_found = 1'b0;
      for (int unsigned k = 1; k <= REQ_NUM; k++) begin
         scan_pos = (32'(last_q) + k) % REQ_NUM;
         for (int unsigned j = 0; j < REQ_NUM; j++) begin
            if (!win_found && (j == scan_pos) && req[j]) begin
               win_found = 1'b1;
               win_pos   = j;
            end
         end
      end

      win_oh    = '0;
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      win_sel   = '0;
      for (int unsigned j = 0; j < REQ_NUM; j++) begin
         if (j == win_pos) begin
            win_oh[j] = 1'b1;
            win_wr    = req_wr[j];
            win_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
            win_sel   = req_sel[j*SEL_WIDTH +: SEL_WIDTH];
         end
      end
   end

   assign wd_expired = (TIMEOUT != 0) && (wd_q == CNT_WIDTH'(TIMEOUT - 1));

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q    <= StIdle;
         last_q     <= IdxW'(REQ_NUM - 1);
         wd_q       <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         transfer_q <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         sel_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  rw_q       <= win_wr;
                  addr_q     <= win_addr;
                  wdata_q    <= win_wdata;
                  sel_q      <= win_sel;
                  gnt_q      <= win_oh;
                  transfer_q <= 1'b1;
                  last_q     <= IdxW'(win_pos);
                  wd_q       <= '0;
                  state_q    <= StBusy;
               end
            end
            StBusy: begin
               // Completion wins over a watchdog expiry in the same cycle.
               if (m_done) begin
                  rdata_q    <= rw_q ? '0 : m_rdata;
                  err_q      <= m_err;
                  ack_q      <= gnt_q;
                  transfer_q <= 1'b0;
                  state_q    <= StDone;
               end else if (wd_expired) begin
                  rdata_q    <= '0;
                  err_q      <= 1'b1;
                  ack_q      <= gnt_q;
                  transfer_q <= 1'b0;
                  state_q    <= StDone;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            StDone: begin
               ack_q   <= '0;
               gnt_q   <= '0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign ack        = ack_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_err    = err_q;
   assign m_transfer = transfer_q;
   assign m_rw       = rw_q;
   assign m_addr     = addr_q;
   assign m_wdata    = wdata_q;
   assign m_sel      = sel_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

   logic        PCLK;
   logic        PRESETn;
   logic [3:0]  req;
   logic [3:0]  req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_sel;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        m_transfer;
   logic        m_rw;
   logic [7:0]  m_addr;
   logic [7:0]  m_wdata;
   logic [0:0]  m_sel;
   logic        m_done;
   logic [7:0]  m_rdata;
   logic        m_err;

   int checks = 0;
   int errors = 0;

   apb_req_arbiter #(
      .ADDR_WIDTH(8), .DATA_WIDTH(8), .REQ_NUM(4), .SEL_WIDTH(1), .TIMEOUT(16), .CNT_WIDTH(8)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_sel(req_sel), .gnt(gnt), .ack(ack), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .m_transfer(m_transfer), .m_rw(m_rw), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_sel(m_sel), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic       rstn;
      logic [3:0] rq;
      logic       done;
      logic [7:0] mrd;
      logic       merr;
      logic [3:0] e_gnt;
      logic [3:0] e_ack;
      logic       e_mt;
      logic       e_rw;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic [7:0] e_rd;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rstn, input logic [3:0] rq, input logic done,
                      input logic [7:0] mrd, input logic merr, input logic [3:0] e_gnt,
                      input logic [3:0] e_ack, input logic e_mt, input logic e_rw,
                      input logic [7:0] e_addr, input logic [7:0] e_wdata,
                      input logic [7:0] e_rd, input logic e_err);
      vec_t v;
      v.rstn = rstn; v.rq = rq; v.done = done; v.mrd = mrd; v.merr = merr;
      v.e_gnt = e_gnt; v.e_ack = e_ack; v.e_mt = e_mt; v.e_rw = e_rw;
      v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rd = e_rd; v.e_err = e_err;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   int cnt;
   logic broke;

   initial begin
      PRESETn   = 1'b0;
      req       = 4'b0000;
      req_wr    = 4'b1001;
      req_addr  = {8'h40, 8'h3C, 8'h20, 8'h10};
      req_wdata = {8'hD8, 8'hC7, 8'hB6, 8'hA5};
      req_sel   = 4'b0100;
      m_done    = 1'b0;
      m_rdata   = 8'h00;
      m_err     = 1'b0;

      //   rstn req  done mrd  merr | gnt   ack   mt rw addr   wdata  rd     err
      add(0, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 0);
      add(1, 4'b0001, 0, 8'h00, 0, 4'b0001, 4'b0000, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b0001, 0, 8'h00, 0, 4'b0001, 4'b0000, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b0001, 1, 8'h77, 0, 4'b0001, 4'b0001, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(0, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 0);
      // all four requesting: order 0,1,2,3,0
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0001, 4'b0000, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1111, 1, 8'h11, 0, 4'b0001, 4'b0001, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0010, 4'b0000, 1, 0, 8'h20, 8'hB6, 8'h00, 0);
      add(1, 4'b1111, 1, 8'h22, 0, 4'b0010, 4'b0010, 0, 0, 8'h20, 8'hB6, 8'h22, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 0, 8'h20, 8'hB6, 8'h22, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0100, 4'b0000, 1, 0, 8'h3C, 8'hC7, 8'h22, 0);
      add(1, 4'b1111, 1, 8'h5A, 1, 4'b0100, 4'b0100, 0, 0, 8'h3C, 8'hC7, 8'h5A, 1);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 0, 8'h3C, 8'hC7, 8'h5A, 1);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b1000, 4'b0000, 1, 1, 8'h40, 8'hD8, 8'h5A, 1);
      add(1, 4'b1111, 1, 8'h33, 0, 4'b1000, 4'b1000, 0, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0001, 4'b0000, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1111, 1, 8'h44, 0, 4'b0001, 4'b0001, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1111, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      // wrap: grant 3, then 1001 -> 0, then 3
      add(1, 4'b1000, 0, 8'h00, 0, 4'b1000, 4'b0000, 1, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1000, 1, 8'h00, 0, 4'b1000, 4'b1000, 0, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1001, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1001, 0, 8'h00, 0, 4'b0001, 4'b0000, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1001, 1, 8'h00, 0, 4'b0001, 4'b0001, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1001, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h10, 8'hA5, 8'h00, 0);
      add(1, 4'b1001, 0, 8'h00, 0, 4'b1000, 4'b0000, 1, 1, 8'h40, 8'hD8, 8'h00, 0);
      add(1, 4'b1001, 1, 8'h55, 1, 4'b1000, 4'b1000, 0, 1, 8'h40, 8'hD8, 8'h00, 1);
      add(1, 4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000, 0, 1, 8'h40, 8'hD8, 8'h00, 1);
      // m_done in IDLE is ignored
      add(1, 4'b0000, 1, 8'hFF, 1, 4'b0000, 4'b0000, 0, 1, 8'h40, 8'hD8, 8'h00, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         PRESETn = vecs[i].rstn;
         req     = vecs[i].rq;
         m_done  = vecs[i].done;
         m_rdata = vecs[i].mrd;
         m_err   = vecs[i].merr;
         tick();
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
         chk($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].e_ack));
         chk($sformatf("v%0d m_transfer", i), 32'(m_transfer), 32'(vecs[i].e_mt));
         chk($sformatf("v%0d m_rw", i), 32'(m_rw), 32'(vecs[i].e_rw));
         chk($sformatf("v%0d m_addr", i), 32'(m_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d m_wdata", i), 32'(m_wdata), 32'(vecs[i].e_wdata));
         chk($sformatf("v%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
      end
      m_done = 1'b0;
      m_err  = 1'b0;

      // Read by req1 leaves nonzero rsp_rdata before the timeout case.
      req = 4'b0010;
      tick();
      chk("rd1 gnt", 32'(gnt), 32'h2);
      m_done  = 1'b1;
      m_rdata = 8'h6E;
      tick();
      chk("rd1 ack", 32'(ack), 32'h2);
      chk("rd1 rsp_rdata", 32'(rsp_rdata), 32'h6E);
      m_done = 1'b0;
      req    = 4'b0000;
      tick();

      // Watchdog: req2 granted, m_done never comes. Fields changed and req dropped after grant.
      req = 4'b0100;
      tick();
      chk("to gnt", 32'(gnt), 32'h4);
      chk("to m_sel", 32'(m_sel), 32'h1);
      cnt   = m_transfer ? 1 : 0;
      req   = 4'b0000;
      req_addr[23:16] = 8'h99;
      broke = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_transfer) begin
            cnt++;
            chk("to m_addr stable", 32'(m_addr), 32'h3C);
         end else begin
            broke = 1'b1;
            break;
         end
      end
      chk("to terminated", 32'(broke), 32'h1);
      chk("to transfer cycles", 32'(cnt), 32'd16);
      chk("to ack", 32'(ack), 32'h4);
      chk("to rsp_err", 32'(rsp_err), 32'h1);
      chk("to rsp_rdata", 32'(rsp_rdata), 32'h0);
      tick();
      chk("to ack cleared", 32'(ack), 32'h0);
      chk("to gnt cleared", 32'(gnt), 32'h0);
      req_addr[23:16] = 8'h3C;

      // Reset while BUSY: no ack, pointer back to favour req0.
      req = 4'b0001;
      tick();
      chk("rst busy gnt", 32'(gnt), 32'h1);
      tick();
      tick();
      PRESETn = 1'b0;
      m_done  = 1'b1;
      tick();
      chk("rst m_transfer", 32'(m_transfer), 32'h0);
      chk("rst gnt", 32'(gnt), 32'h0);
      chk("rst ack", 32'(ack), 32'h0);
      PRESETn = 1'b1;
      m_done  = 1'b0;
      req     = 4'b1001;
      tick();
      chk("rst ptr gnt", 32'(gnt), 32'h1);
      m_done = 1'b1;
      tick();
      chk("rst ptr ack", 32'(ack), 32'h1);
      m_done = 1'b0;
      req    = 4'b1000;
      tick();
      tick();
      chk("solo req3 gnt", 32'(gnt), 32'h8);
      chk("solo req3 m_addr", 32'(m_addr), 32'h40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
